// File: rtl/cbus_rr_arbiter_pkg.sv
// cbus_rr_arbiter_pkg: CBus request/response types and arbiter state encoding
package cbus_rr_arbiter_pkg;
  typedef struct packed {
    logic        valid;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  len;
  } cbus_req_t;
  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] rdata;
  } cbus_resp_t;
  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;
endpackage

// File: rtl/cbus_rr_pick.sv
// cbus_rr_pick: combinational winner select, round-robin from ptr or highest index
module cbus_rr_pick #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] valid,
  input  logic [W-1:0] ptr,
  input  logic         mode,
  output logic         any,
  output logic [W-1:0] winner
);
  logic [2*N-1:0] dbl;
  logic found;
  always_comb begin
    dbl = {valid, valid};
    any = |valid;
    winner = '0;
    found = 1'b0;
    if (mode) begin
      for (int i = 0; i < 2*N; i++) begin
        if (!found && i >= int'(ptr) && dbl[i]) begin
          found = 1'b1;
          winner = (i >= N) ? W'(i - N) : W'(i);
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (valid[i]) winner = W'(i);
      end
    end
  end
endmodule

// File: rtl/cbus_rr_arbiter.sv
// cbus_rr_arbiter: N-to-1 CBus arbiter holding each grant until the burst's last beat
module cbus_rr_arbiter
  import cbus_rr_arbiter_pkg::*;
#(
  parameter int N_PORTS = 2,
  parameter int RR_MODE = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  cbus_req_t [N_PORTS-1:0] ireqs,
  output cbus_resp_t [N_PORTS-1:0] iresps,
  output cbus_req_t               oreq,
  input  cbus_resp_t              oresp,
  output logic                    grant_vld,
  output logic [(N_PORTS>1 ? $clog2(N_PORTS) : 1)-1:0] grant_idx
);
  localparam int IDX_W = N_PORTS > 1 ? $clog2(N_PORTS) : 1;
  arb_state_t state_q, state_d;
  logic [IDX_W-1:0] grant_idx_q, grant_idx_d, rr_ptr_q, rr_ptr_d, winner;
  logic [N_PORTS-1:0] vld;
  logic any;
  cbus_rr_pick #(.N(N_PORTS), .W(IDX_W)) u_pick (
    .valid (vld),
    .ptr   (rr_ptr_q),
    .mode  (1'(RR_MODE)),
    .any   (any),
    .winner(winner)
  );
  always_comb begin
    for (int i = 0; i < N_PORTS; i++) vld[i] = ireqs[i].valid;
    state_d = state_q;
    grant_idx_d = grant_idx_q;
    rr_ptr_d = rr_ptr_q;
    oreq = '0;
    iresps = '0;
    if (state_q == ARB_IDLE) begin
      if (any) begin
        grant_idx_d = winner;
        state_d = ARB_BUSY;
      end
    end else begin
      oreq = ireqs[grant_idx_q];
      iresps[grant_idx_q] = oresp;
      if (oresp.ready && oresp.last) begin
        state_d = ARB_IDLE;
        if (RR_MODE != 0)
          rr_ptr_d = (grant_idx_q == IDX_W'(N_PORTS-1)) ? '0 : grant_idx_q + IDX_W'(1);
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      grant_idx_q <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      grant_idx_q <= grant_idx_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end
  assign grant_vld = state_q == ARB_BUSY;
  assign grant_idx = grant_idx_q;
endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// tb_cbus_rr_arbiter: random traffic on a 3-port RR and a 4-port fixed-priority arbiter vs a burst-level model
module tb_cbus_rr_arbiter;
  import cbus_rr_arbiter_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  cbus_req_t [3:0] rq [2];
  cbus_resp_t rsp [2];
  cbus_resp_t [2:0] irs_a;
  cbus_resp_t [3:0] irs_b;
  cbus_req_t oreq_a, oreq_b;
  logic gv_a, gv_b;
  logic [1:0] gi_a, gi_b;
  int tests = 0;
  int fails = 0;
  int own [2];
  int ptr [2];
  int np [2] = '{3, 4};
  int rr [2] = '{1, 0};
  cbus_rr_arbiter #(.N_PORTS(3), .RR_MODE(1)) u_a (
    .clk(clk), .reset(reset), .ireqs(rq[0][2:0]), .iresps(irs_a),
    .oreq(oreq_a), .oresp(rsp[0]), .grant_vld(gv_a), .grant_idx(gi_a)
  );
  cbus_rr_arbiter #(.N_PORTS(4), .RR_MODE(0)) u_b (
    .clk(clk), .reset(reset), .ireqs(rq[1]), .iresps(irs_b),
    .oreq(oreq_b), .oresp(rsp[1]), .grant_vld(gv_b), .grant_idx(gi_b)
  );
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask
  initial begin
    logic do_rst;
    cbus_req_t exp_q;
    cbus_resp_t exp_r;
    int w;
    own = '{-1, -1};
    ptr = '{0, 0};
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      do_rst = c < 2 || (c > 20 && (own[0] >= 0 || own[1] >= 0) && $urandom_range(0, 99) == 0);
      reset = do_rst;
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < 4; i++) begin
          rq[d][i].wen = 1'($urandom_range(0, 1));
          rq[d][i].addr = $urandom;
          rq[d][i].wdata = $urandom;
          rq[d][i].len = 4'($urandom_range(0, 15));
          rq[d][i].valid = (own[d] == i) ? 1'b1 : 1'($urandom_range(0, 2) != 0);
        end
        rsp[d].ready = 1'($urandom_range(0, 1));
        rsp[d].last = 1'($urandom_range(0, 3) == 0);
        rsp[d].rdata = $urandom;
      end
      if (do_rst) begin
        own = '{-1, -1};
        ptr = '{0, 0};
      end
      #1;
      for (int d = 0; d < 2; d++) begin
        check($sformatf("d%0d grant_vld", d), 128'(d ? gv_b : gv_a), 128'(own[d] >= 0));
        if (own[d] >= 0)
          check($sformatf("d%0d grant_idx", d), 128'(d ? gi_b : gi_a), 128'(own[d]));
        exp_q = (own[d] >= 0) ? rq[d][own[d]] : '0;
        check($sformatf("d%0d oreq", d), 128'(d ? oreq_b : oreq_a), 128'(exp_q));
        for (int i = 0; i < np[d]; i++) begin
          exp_r = (own[d] == i) ? rsp[d] : '0;
          check($sformatf("d%0d iresps[%0d]", d, i), 128'(d ? irs_b[i] : irs_a[i]), 128'(exp_r));
        end
      end
      if (!do_rst) begin
        for (int d = 0; d < 2; d++) begin
          if (own[d] < 0) begin
            w = -1;
            if (rr[d] != 0) begin
              for (int k = 0; k < np[d]; k++)
                if (w < 0 && rq[d][(ptr[d] + k) % np[d]].valid) w = (ptr[d] + k) % np[d];
            end else begin
              for (int i = 0; i < np[d]; i++)
                if (rq[d][i].valid) w = i;
            end
            own[d] = w;
          end else if (rsp[d].ready && rsp[d].last) begin
            if (rr[d] != 0) ptr[d] = (own[d] + 1) % np[d];
            own[d] = -1;
          end
        end
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
